// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the adder AXI-lite master sequencer.
package adder_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_RD_SUM,
        S_RESP
    } state_t;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    localparam logic [7:0] DEF_A_ADDR   = 8'h00;
    localparam logic [7:0] DEF_B_ADDR   = 8'h04;
    localparam logic [7:0] DEF_SUM_ADDR = 8'h08;

endpackage

// File: rtl/adder_ctrl_wr.sv
// Single AXI-lite write engine (AW/W/B); reused for both operand writes.
module adder_ctrl_wr
    import adder_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic                  bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic                  done,
    output logic                  err,
    output logic                  timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic          aw_done, w_done, b_hs;
    logic [CW-1:0] cnt;

    // A B response before both AW and W have completed is a protocol error.
    assign b_hs    = bready & bvalid;
    assign done    = b_hs;
    assign err     = b_hs & ((bresp == RESP_ERR) | ~(aw_done & w_done));
    assign timeout = bready & ~b_hs & (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            awaddr  <= '0;
            wdata   <= '0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            awaddr  <= addr;
            wdata   <= data;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            bready  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            cnt     <= '0;
        end else if (b_hs | timeout) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            if (awvalid & awready) begin
                awvalid <= 1'b0;
                aw_done <= 1'b1;
            end
            if (wvalid & wready) begin
                wvalid <= 1'b0;
                w_done <= 1'b1;
            end
            if (bready && cnt != CW'(TIMEOUT))
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adder_ctrl.sv
// Sequences one add per command: write A, write B, read sum, return result.
module adder_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] A_ADDR     = ADDR_WIDTH'(DEF_A_ADDR),
    parameter logic [ADDR_WIDTH-1:0] B_ADDR     = ADDR_WIDTH'(DEF_B_ADDR),
    parameter logic [ADDR_WIDTH-1:0] SUM_ADDR   = ADDR_WIDTH'(DEF_SUM_ADDR),
    parameter int                    TIMEOUT    = 255
) (
    input  logic                    m1_axi_aclk,
    input  logic                    m1_axi_areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_sum,
    output logic                    res_err,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
    output logic                    m1_axi_awvalid,
    input  logic                    m1_axi_awready,
    output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
    output logic                    m1_axi_wvalid,
    input  logic                    m1_axi_wready,
    input  logic                    m1_axi_bresp,
    input  logic                    m1_axi_bvalid,
    output logic                    m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
    output logic                    m1_axi_arvalid,
    input  logic                    m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
    input  logic                    m1_axi_rresp,
    input  logic                    m1_axi_rvalid,
    output logic                    m1_axi_rready
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                state, next_state;
    logic [DATA_WIDTH-1:0] b_q, wr_data;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [CW-1:0]         rcnt;
    logic                  cmd_accept, wr_start, rd_start;
    logic                  wr_done, wr_err, wr_tmo, r_hs, rd_tmo, fail;

    assign m1_axi_wstrb = '1;
    assign r_hs   = m1_axi_rready & m1_axi_rvalid;
    assign rd_tmo = (state == S_RD_SUM) & ~r_hs & (rcnt == CW'(TIMEOUT - 1));
    assign fail   = wr_err | wr_tmo | rd_tmo;

    adder_ctrl_wr #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) u_wr (
        .clk     (m1_axi_aclk),
        .rst     (m1_axi_areset),
        .start   (wr_start),
        .addr    (wr_addr),
        .data    (wr_data),
        .awaddr  (m1_axi_awaddr),
        .awvalid (m1_axi_awvalid),
        .awready (m1_axi_awready),
        .wdata   (m1_axi_wdata),
        .wvalid  (m1_axi_wvalid),
        .wready  (m1_axi_wready),
        .bresp   (m1_axi_bresp),
        .bvalid  (m1_axi_bvalid),
        .bready  (m1_axi_bready),
        .done    (wr_done),
        .err     (wr_err),
        .timeout (wr_tmo)
    );

    always_ff @(posedge m1_axi_aclk) begin
        if (m1_axi_areset) state <= S_IDLE;
        else               state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (cmd_valid && cmd_ready) next_state = S_WR_A;
            S_WR_A:   if (wr_tmo || wr_err)       next_state = S_RESP;
                      else if (wr_done)           next_state = S_WR_B;
            S_WR_B:   if (wr_tmo || wr_err)       next_state = S_RESP;
                      else if (wr_done)           next_state = S_RD_SUM;
            S_RD_SUM: if (r_hs || rd_tmo)         next_state = S_RESP;
            S_RESP:   if (res_valid && res_ready) next_state = S_IDLE;
            default:                              next_state = S_IDLE;
        endcase
    end

    // Operand A goes straight from the command port on accept; B comes from its latch.
    always_comb begin
        cmd_accept = (state == S_IDLE) && (next_state == S_WR_A);
        wr_start   = cmd_accept || ((state == S_WR_A) && (next_state == S_WR_B));
        rd_start   = (state == S_WR_B) && (next_state == S_RD_SUM);
        wr_addr    = (state == S_IDLE) ? A_ADDR : B_ADDR;
        wr_data    = (state == S_IDLE) ? cmd_a : b_q;
    end

    always_ff @(posedge m1_axi_aclk) begin
        if (m1_axi_areset) begin
            cmd_ready      <= 1'b0;
            busy           <= 1'b0;
            res_valid      <= 1'b0;
            res_sum        <= '0;
            res_err        <= 1'b0;
            b_q            <= '0;
            m1_axi_araddr  <= '0;
            m1_axi_arvalid <= 1'b0;
            m1_axi_rready  <= 1'b0;
            rcnt           <= '0;
        end else begin
            cmd_ready <= (next_state == S_IDLE);
            busy      <= (next_state != S_IDLE);
            res_valid <= (state == S_RESP) && !(res_valid && res_ready);

            if (cmd_accept) begin
                b_q     <= cmd_b;
                res_sum <= '0;
                res_err <= 1'b0;
            end else if (r_hs) begin
                res_sum <= (m1_axi_rresp == RESP_OK) ? m1_axi_rdata : '0;
                res_err <= (m1_axi_rresp != RESP_OK);
            end else if (fail) begin
                res_sum <= '0;
                res_err <= 1'b1;
            end

            if (rd_start) begin
                m1_axi_araddr  <= SUM_ADDR;
                m1_axi_arvalid <= 1'b1;
                m1_axi_rready  <= 1'b1;
                rcnt           <= '0;
            end else if (r_hs || rd_tmo) begin
                m1_axi_arvalid <= 1'b0;
                m1_axi_rready  <= 1'b0;
            end else if (state == S_RD_SUM) begin
                if (m1_axi_arvalid && m1_axi_arready) m1_axi_arvalid <= 1'b0;
                if (rcnt != CW'(TIMEOUT)) rcnt <= rcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_ctrl.sv
// Directed bench: a small adder-register slave model shared by two controllers
// (default timeout and TIMEOUT=4), selected by sel.
module tb_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0, t_cmd_valid = 1'b0, res_ready = 1'b0;
    logic [31:0] cmd_a = '0, cmd_b = '0;

    logic        cmd_ready, res_valid, res_err, busy;
    logic        t_cmd_ready, t_res_valid, t_res_err, t_busy;
    logic [31:0] res_sum, t_res_sum, wdata, t_wdata;
    logic [7:0]  awaddr, araddr, t_awaddr, t_araddr;
    logic [3:0]  wstrb, t_wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        t_awvalid, t_wvalid, t_bready, t_arvalid, t_rready;

    logic        sel = 1'b0;
    int          aw_delay = 0;
    logic        berr_a = 1'b0, ar_block = 1'b0;
    logic        awready, wready, arready, bvalid, bresp, rvalid, rresp;
    logic [31:0] rdata;

    adder_ctrl dut (
        .m1_axi_aclk(clk), .m1_axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_err(res_err),
        .busy(busy),
        .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(awready),
        .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid), .m1_axi_wready(wready),
        .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid), .m1_axi_bready(bready),
        .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid), .m1_axi_arready(arready),
        .m1_axi_rdata(rdata), .m1_axi_rresp(rresp), .m1_axi_rvalid(rvalid), .m1_axi_rready(rready)
    );

    adder_ctrl #(.TIMEOUT(4)) dut_t (
        .m1_axi_aclk(clk), .m1_axi_areset(rst),
        .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(t_res_valid), .res_ready(res_ready), .res_sum(t_res_sum), .res_err(t_res_err),
        .busy(t_busy),
        .m1_axi_awaddr(t_awaddr), .m1_axi_awvalid(t_awvalid), .m1_axi_awready(awready),
        .m1_axi_wdata(t_wdata), .m1_axi_wstrb(t_wstrb), .m1_axi_wvalid(t_wvalid), .m1_axi_wready(wready),
        .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid), .m1_axi_bready(t_bready),
        .m1_axi_araddr(t_araddr), .m1_axi_arvalid(t_arvalid), .m1_axi_arready(arready),
        .m1_axi_rdata(rdata), .m1_axi_rresp(rresp), .m1_axi_rvalid(rvalid), .m1_axi_rready(t_rready)
    );

    // Slave model: registers at 0x00/0x04, sum at 0x08, B/R one cycle after handshake.
    logic [7:0]  s_awaddr, s_araddr, wa, last_ar;
    logic [31:0] s_wdata, wd, reg_a, reg_b;
    logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready, aw_got, w_got;
    int          aw_wait, n_wr = 0, n_rd = 0;

    assign s_awaddr  = sel ? t_awaddr  : awaddr;
    assign s_awvalid = sel ? t_awvalid : awvalid;
    assign s_wdata   = sel ? t_wdata   : wdata;
    assign s_wvalid  = sel ? t_wvalid  : wvalid;
    assign s_bready  = sel ? t_bready  : bready;
    assign s_araddr  = sel ? t_araddr  : araddr;
    assign s_arvalid = sel ? t_arvalid : arvalid;
    assign s_rready  = sel ? t_rready  : rready;
    assign awready   = (aw_wait >= aw_delay);
    assign wready    = 1'b1;
    assign arready   = !ar_block;
    assign rresp     = 1'b0;

    wire       aw_hs = s_awvalid && awready;
    wire       w_hs  = s_wvalid && wready;
    wire [7:0] cur_a = aw_hs ? s_awaddr : wa;
    wire [31:0] cur_d = w_hs ? s_wdata : wd;

    always @(posedge clk) begin
        if (rst) begin
            bvalid <= 1'b0; bresp <= 1'b0; rvalid <= 1'b0; rdata <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0;
        end else begin
            aw_wait <= (s_awvalid && !awready) ? aw_wait + 1 : 0;
            if (aw_hs) begin aw_got <= 1'b1; wa <= s_awaddr; end
            if (w_hs)  begin w_got  <= 1'b1; wd <= s_wdata;  end
            if (bvalid && s_bready) bvalid <= 1'b0;
            if ((aw_got || aw_hs) && (w_got || w_hs) && !bvalid) begin
                bvalid <= 1'b1;
                bresp  <= berr_a && (cur_a == 8'h00);
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                n_wr   <= n_wr + 1;
                if (cur_a == 8'h00) reg_a <= cur_d;
                if (cur_a == 8'h04) reg_b <= cur_d;
            end
            if (s_arvalid && arready) begin
                rvalid  <= 1'b1;
                rdata   <= reg_a + reg_b;
                last_ar <= s_araddr;
                n_rd    <= n_rd + 1;
            end else if (rvalid && s_rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input bit ts, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        cmd_a = a;
        cmd_b = b;
        while (!(ts ? t_cmd_ready : cmd_ready) && n < 50) begin @(posedge clk); #1; n++; end
        chk("cmd_ready before issue", ts ? t_cmd_ready : cmd_ready, 1);
        if (ts) t_cmd_valid = 1'b1; else cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        t_cmd_valid = 1'b0;
    endtask

    // Cycles from the command handshake edge until res_valid, counting arvalid-high samples.
    task automatic wait_res(input bit ts, output int lat, output int nar);
        lat = 0;
        nar = 0;
        while (!(ts ? t_res_valid : res_valid) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (ts ? t_arvalid : arvalid) nar++;
        end
        chk("res_valid seen", ts ? t_res_valid : res_valid, 1);
    endtask

    task automatic finish_res(input bit ts);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("res_valid after handshake", ts ? t_res_valid : res_valid, 0);
        chk("cmd_ready 1 cycle after result", ts ? t_cmd_ready : cmd_ready, 1);
    endtask

    typedef struct { logic [31:0] a, b, sum; } vec_t;
    vec_t vecs[5];

    initial begin
        int lat, nar, naw, nw, wr0, rd0;
        vecs[0] = '{32'h0000AABB, 32'h0000CCDD, 32'h00017798};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[2] = '{32'h00000000, 32'h00000000, 32'h00000000};
        vecs[3] = '{32'h12345678, 32'h11111111, 32'h23456789};
        vecs[4] = '{32'h80000000, 32'h80000000, 32'h00000000};

        repeat (2) @(posedge clk);
        #1;
        chk("reset flags", {cmd_ready, res_valid, res_err, busy, awvalid, wvalid, bready, arvalid, rready}, 0);
        chk("reset res_sum", res_sum, 0);
        chk("reset addrs", {awaddr, araddr}, 0);
        chk("reset wdata", wdata, 0);
        chk("reset wstrb", wstrb, 4'hF);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("cmd_ready after reset", cmd_ready, 1);

        for (int i = 0; i < 5; i++) begin
            issue(0, vecs[i].a, vecs[i].b);
            chk("busy", busy, 1);
            wait_res(0, lat, nar);
            chk("latency", lat, 7);
            chk("sum", res_sum, vecs[i].sum);
            chk("err", res_err, 0);
            chk("reg at 0x00", reg_a, vecs[i].a);
            chk("reg at 0x04", reg_b, vecs[i].b);
            chk("read addr", last_ar, 8'h08);
            finish_res(0);
        end

        // AW held off for 3 cycles, W accepted immediately
        aw_delay = 3;
        issue(0, 32'd1, 32'd2);
        naw = 0;
        nw = 0;
        for (int i = 0; i < 5; i++) begin
            if (awvalid) naw++;
            if (wvalid) nw++;
            @(posedge clk); #1;
        end
        chk("split awvalid cycles", naw, 4);
        chk("split wvalid cycles", nw, 1);
        wait_res(0, lat, nar);
        chk("split sum", res_sum, 3);
        chk("split err", res_err, 0);
        finish_res(0);
        aw_delay = 0;

        // Error response on the A write
        berr_a = 1'b1;
        wr0 = n_wr;
        rd0 = n_rd;
        issue(0, 32'h55, 32'h66);
        wait_res(0, lat, nar);
        chk("bresp err", res_err, 1);
        chk("bresp sum", res_sum, 0);
        chk("bresp writes", n_wr - wr0, 1);
        chk("bresp reads", n_rd - rd0, 0);
        finish_res(0);
        berr_a = 1'b0;

        // Read address never accepted on the TIMEOUT=4 controller
        sel = 1'b1;
        ar_block = 1'b1;
        issue(1, 32'h10, 32'h20);
        wait_res(1, lat, nar);
        chk("timeout arvalid cycles", nar, 4);
        chk("timeout arvalid low", t_arvalid, 0);
        chk("timeout err", t_res_err, 1);
        chk("timeout sum", t_res_sum, 0);
        chk("timeout wstrb", t_wstrb, 4'hF);
        finish_res(1);
        chk("timeout busy", t_busy, 0);
        ar_block = 1'b0;
        sel = 1'b0;

        // Result backpressure with a stray command that must be ignored
        wr0 = n_wr;
        issue(0, 32'd5, 32'd6);
        wait_res(0, lat, nar);
        cmd_valid = 1'b1;
        cmd_a = 32'hDEAD;
        for (int i = 0; i < 10; i++) begin
            chk("bp res_valid", res_valid, 1);
            chk("bp res_sum", res_sum, 11);
            chk("bp cmd_ready", cmd_ready, 0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("bp writes", n_wr - wr0, 2);
        finish_res(0);

        // Reset asserted during the B write
        issue(0, 32'd7, 32'd8);
        for (int i = 0; i < 20 && !(awvalid && awaddr == 8'h04); i++) begin
            @(posedge clk); #1;
        end
        chk("reached WR_B", {awvalid, awaddr}, {1'b1, 8'h04});
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid reset valids", {awvalid, wvalid, bready, arvalid, rready, res_valid}, 0);
        chk("mid reset busy", busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("cmd_ready after mid reset", cmd_ready, 1);
        issue(0, 32'd9, 32'd10);
        wait_res(0, lat, nar);
        chk("post reset latency", lat, 7);
        chk("post reset sum", res_sum, 19);
        chk("post reset err", res_err, 0);
        finish_res(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
